// File: rtl/shift_sequencer.sv
// shift_sequencer
// Multi-cycle controller for a shared 16-bit barrel shifter whose immediate is a
// 5-bit signed step (+ve = left, -ve = logical right).  A request carries an
// operand and an AMT_W-bit signed shift amount.  The amount is split into steps
// of at most STEP_MAX, and one step is applied per clock.  Each shifter result is
// fed back into the accumulator, and the final value is returned over a
// valid/ready handshake.
//
// Optional feature macro: SHIFT_SEQ_EARLY_EN
//    When defined, a request whose amount magnitude is at least DATA_W skips the
//    RUN phase entirely.  Every bit is shifted out in that case, so the result
//    is always zero.
//
// State flow: IDLE -> RUN -> DONE -> IDLE.  A zero amount goes IDLE -> DONE.
// Reset is synchronous and active-high.  It discards any request or result that
// is in flight.

module shift_sequencer #(
   parameter int DATA_W   = 16,
   parameter int AMT_W    = 8,
   parameter int STEP_MAX = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_data,
   input  logic [AMT_W-1:0]  req_amt,
   output logic [4:0]        sh_imm,
   output logic [DATA_W-1:0] sh_in,
   input  logic [DATA_W-1:0] sh_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy
);

   // The remaining count carries one extra bit so that the most negative amount
   // (-2^(AMT_W-1)) has a representable magnitude and is handled exactly.
   localparam int                REM_W    = AMT_W + 1;
   localparam logic [REM_W-1:0] STEP_LIM = REM_W'(STEP_MAX);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [REM_W-1:0]    rem_q, rem_d;

   logic                remNeg;
   logic [REM_W-1:0]    remMag;
   logic [REM_W-1:0]    stepMag;
   logic [REM_W-1:0]    stepVal;
   logic [REM_W-1:0]    remNext;
   logic [REM_W-1:0]    reqAmtExt;

   // The current step is derived from the remaining count.  Its magnitude is
   // clamped to STEP_MAX, and the sign is kept so that the shift direction never
   // changes part-way through a request.
   assign remNeg    = rem_q[REM_W-1];
   assign remMag    = remNeg ? (~rem_q + 1'b1) : rem_q;
   assign stepMag   = (remMag > STEP_LIM) ? STEP_LIM : remMag;
   assign stepVal   = remNeg ? (~stepMag + 1'b1) : stepMag;
   assign remNext   = rem_q - stepVal;
   assign reqAmtExt = {req_amt[AMT_W-1], req_amt};

`ifdef SHIFT_SEQ_EARLY_EN
   logic [REM_W-1:0]    reqMag;
   logic                farShift;

   // Any amount of DATA_W or more in either direction clears the operand, so the
   // answer can be produced immediately.
   assign reqMag   = reqAmtExt[REM_W-1] ? (~reqAmtExt + 1'b1) : reqAmtExt;
   assign farShift = (reqMag >= REM_W'(DATA_W));
`endif

   // State and datapath registers; reset returns to an empty IDLE machine.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
      end
   end

   // Next-state and next-datapath logic: load on accept, iterate the shifter in
   // RUN, and hold the result in DONE until it is consumed.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               acc_d   = req_data;
               rem_d   = reqAmtExt;
               state_d = (reqAmtExt == '0) ? DONE : RUN;
`ifdef SHIFT_SEQ_EARLY_EN
               if (farShift) begin
                  acc_d   = '0;
                  rem_d   = '0;
                  state_d = DONE;
               end
`endif
            end
         end
         RUN: begin
            acc_d = sh_out;
            rem_d = remNext;
            if (remNext == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the registered state and the accumulator only.
   // No output depends combinationally on a handshake input.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b0;
      sh_imm    = 5'd0;
      sh_in     = acc_q;
      rsp_data  = acc_q;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
         end
         RUN: begin
            busy   = 1'b1;
            sh_imm = stepVal[4:0];
         end
         DONE: begin
            busy      = 1'b1;
            rsp_valid = 1'b1;
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

endmodule
